// File: rtl/snoop_bus_arbiter_pkg.sv
// types: shared snoop-bus arbitration types, widths and FSM states
package types;
  localparam int NUM_CPUS = 4;
  localparam int CPU_ID_W = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
  typedef logic [CPU_ID_W-1:0] cpu_id_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_OWNED, ARB_RELEASE} arb_state_e;
endpackage

// File: rtl/snoop_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set req bit at or above ptr, wrapping
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] pick,
  output logic [W-1:0] pick_id,
  output logic         pick_valid
);
  int j;
  always_comb begin
    pick = '0;
    pick_id = '0;
    pick_valid = 1'b0;
    j = 0;
    // scanning from farthest to nearest lets the nearest hit overwrite the rest
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        pick = N'(1) << j;
        pick_id = W'(j);
        pick_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: tenure-holding round-robin snoop bus arbiter; ARB_TENURE_LIMIT_EN adds a tenure timeout
module snoop_bus_arbiter
  import types::*;
#(
  parameter int NUM_REQ    = NUM_CPUS,
  parameter int MAX_TENURE = 64,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  input  logic [NUM_REQ-1:0] busy,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               tenure_timeout
);
  arb_state_e state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, pick;
  logic [ID_W-1:0] id_q, id_d, ptr_q, ptr_d, pick_id;
  logic pick_valid, fin, expire;

  rr_picker #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .req(req),
    .ptr(ptr_q),
    .pick(pick),
    .pick_id(pick_id),
    .pick_valid(pick_valid)
  );

`ifdef ARB_TENURE_LIMIT_EN
  localparam int CW = $clog2(MAX_TENURE) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tmo_q, tmo_d;
  assign expire = (state_q == ARB_OWNED) && (cnt_q == CW'(MAX_TENURE - 1));
  always_comb begin
    cnt_d = (state_q == ARB_OWNED) ? cnt_q + CW'(1) : '0;
    tmo_d = expire && !done[id_q] && req[id_q];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  assign tenure_timeout = tmo_q;
`else
  assign expire = 1'b0;
  assign tenure_timeout = (MAX_TENURE < 0);
`endif

  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    id_d = id_q;
    ptr_d = ptr_q;
    fin = done[id_q] || !req[id_q] || expire;
    case (state_q)
      ARB_IDLE:
        if (pick_valid && !(|busy)) begin
          state_d = ARB_OWNED;
          gnt_d = pick;
          id_d = pick_id;
        end
      ARB_OWNED:
        if (fin) begin
          state_d = ARB_RELEASE;
          gnt_d = '0;
          ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
        end
      default: begin
        state_d = ARB_IDLE;
        gnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q <= '0;
      id_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
    end

  assign gnt = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id = id_q;
endmodule
